// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, two synchronous
// write ports (port 1 wins on collision), optional bypass / zero entry, bulk-clear sweep.
module regfile_param #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned AW      = 3,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    addrA,
  input  logic [AW-1:0]    addrB,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  input  logic [AW-1:0]    inAddr,
  input  logic [WIDTH-1:0] inData,
  input  logic             WE,
  input  logic [AW-1:0]    inAddr1,
  input  logic [WIDTH-1:0] inData1,
  input  logic             WE1,
  input  logic             clr_req,
  output logic             busy,
  output logic             wcol
);

  localparam int unsigned   DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             wcol_q, wcol_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             idle;
  logic             we0_eff;
  logic             we1_eff;
  logic             byp_en;
  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  assign idle    = (state_q == IDLE);
  assign byp_en  = (BYPASS != 0) && idle;
  assign we0_eff = idle && WE  && !((ZERO_R0 != 0) && (inAddr  == '0));
  assign we1_eff = idle && WE1 && !((ZERO_R0 != 0) && (inAddr1 == '0));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // The collision is reported even when ZERO_R0 drops both writes to entry 0.
  assign wcol_d = idle && WE && WE1 && (inAddr == inAddr1);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we0_eff) begin
      mem_d[inAddr] = inData;
    end
    // Port 1 is applied after port 0 so it wins a same-address collision.
    if (we1_eff) begin
      mem_d[inAddr1] = inData1;
    end
    if (state_q == CLEAR) begin
      mem_d[ptr_q] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      wcol_q  <= 1'b0;
      // NOTE: the storage array is reset too, because reads of unwritten entries must return 0.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wcol_q  <= wcol_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_addr[0] = addrA;
  assign rd_addr[1] = addrB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if ((ZERO_R0 != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
      end else if (byp_en && WE1 && (inAddr1 == rd_addr[p])) begin
        rd_data[p] = inData1;
      end else if (byp_en && WE && (inAddr == rd_addr[p])) begin
        rd_data[p] = inData;
      end else begin
        rd_data[p] = mem_q[rd_addr[p]];
      end
    end
  end

  assign outA = rd_data[0];
  assign outB = rd_data[1];
  assign busy = (state_q == CLEAR);
  assign wcol = wcol_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: two regfile_param instances (bypass on / zero-entry on)
// share stimulus and are compared against a behavioural array model.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  addrA, addrB, inAddr, inAddr1;
  logic [15:0] inData, inData1;
  logic        WE, WE1, clr_req;

  logic [15:0] outA_w [2];
  logic [15:0] outB_w [2];
  logic        busy_w [2];
  logic        wcol_w [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: BYPASS=1, ZERO_R0=0.  Instance 1: BYPASS=0, ZERO_R0=1.
  regfile_param #(.WIDTH(16), .AW(3), .BYPASS(1), .ZERO_R0(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .addrA(addrA), .addrB(addrB),
    .outA(outA_w[0]), .outB(outB_w[0]),
    .inAddr(inAddr), .inData(inData), .WE(WE),
    .inAddr1(inAddr1), .inData1(inData1), .WE1(WE1),
    .clr_req(clr_req), .busy(busy_w[0]), .wcol(wcol_w[0])
  );

  regfile_param #(.WIDTH(16), .AW(3), .BYPASS(0), .ZERO_R0(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .addrA(addrA), .addrB(addrB),
    .outA(outA_w[1]), .outB(outB_w[1]),
    .inAddr(inAddr), .inData(inData), .WE(WE),
    .inAddr1(inAddr1), .inData1(inData1), .WE1(WE1),
    .clr_req(clr_req), .busy(busy_w[1]), .wcol(wcol_w[1])
  );

  // Reference model: contents per instance, sweep progress, expected wcol.
  logic [15:0] m [2][8];
  bit          sweeping;
  int          swept;
  bit          exp_wcol;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 8; a++) m[c][a] = 16'h0;
      sweeping = 0;
      swept    = 0;
      exp_wcol = 0;
    end else if (sweeping) begin
      for (int c = 0; c < 2; c++) m[c][swept] = 16'h0;
      swept = swept + 1;
      if (swept == 8) begin
        sweeping = 0;
        swept    = 0;
      end
      exp_wcol = 0;
    end else begin
      exp_wcol = WE && WE1 && (inAddr == inAddr1);
      for (int c = 0; c < 2; c++) begin
        if (WE  && !(c == 1 && inAddr  == 3'd0)) m[c][inAddr]  = inData;
        if (WE1 && !(c == 1 && inAddr1 == 3'd0)) m[c][inAddr1] = inData1;
      end
      if (clr_req) begin
        sweeping = 1;
        swept    = 0;
      end
    end
  end

  function automatic logic [15:0] exp_read(int c, logic [2:0] a);
    if (c == 1 && a == 3'd0) return 16'h0;
    if (c == 0 && !sweeping && WE1 && inAddr1 == a) return inData1;
    if (c == 0 && !sweeping && WE  && inAddr  == a) return inData;
    return m[c][a];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s_outA%0d", tag, c), 32'(outA_w[c]), 32'(exp_read(c, addrA)));
      check($sformatf("%s_outB%0d", tag, c), 32'(outB_w[c]), 32'(exp_read(c, addrB)));
      check($sformatf("%s_busy%0d", tag, c), 32'(busy_w[c]), 32'(sweeping));
      check($sformatf("%s_wcol%0d", tag, c), 32'(wcol_w[c]), 32'(exp_wcol));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      addrA = 3'(i);
      addrB = 3'(7 - i);
      #1;
      check($sformatf("%s_A0_%0d", tag, i), 32'(outA_w[0]), 32'h0);
      check($sformatf("%s_B1_%0d", tag, i), 32'(outB_w[1]), 32'h0);
      check_all(tag);
    end
  endtask

  task automatic fill_all();
    WE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inAddr = 3'(i);
      inData = 16'h0a00 + 16'(i) + 16'h1;
      step();
    end
    WE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    rst_n = 1'b0; addrA = 0; addrB = 0; inAddr = 0; inAddr1 = 0;
    inData = 0; inData1 = 0; WE = 0; WE1 = 0; clr_req = 0;

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_busy", 32'(busy_w[0]), 32'h0);
    rst_n = 1'b1;
    #1;

    // Basic writes through port 0.
    WE = 1; inAddr = 3'd4; inData = 16'h00ff; step();
    inAddr = 3'd5; inData = 16'h00ee; step();
    WE = 0; addrA = 3'd4; addrB = 3'd5; #1;
    check("basic_A", 32'(outA_w[0]), 32'h00ff);
    check("basic_B", 32'(outB_w[1]), 32'h00ee);
    check_all("basic");

    // Same-address collision: port 1 wins, wcol pulses one cycle.
    WE = 1; WE1 = 1; inAddr = 3'd3; inAddr1 = 3'd3; inData = 16'h1111; inData1 = 16'h2222;
    step();
    WE = 0; WE1 = 0; addrA = 3'd3; #1;
    check("col_wcol", 32'(wcol_w[0]), 32'h1);
    check("col_data", 32'(outA_w[1]), 32'h2222);
    check_all("col");
    step();
    check("col_wcol_clr", 32'(wcol_w[1]), 32'h0);

    // Bypass: visible before the edge on instance 0 only.
    addrA = 3'd6; WE1 = 1; inAddr1 = 3'd6; inData1 = 16'hbeef; #1;
    check("byp_on", 32'(outA_w[0]), 32'hbeef);
    check("byp_off_pre", 32'(outA_w[1]), 32'h0);
    check_all("byp");
    step();
    WE1 = 0; #1;
    check("byp_off_post", 32'(outA_w[1]), 32'hbeef);

    // Zero entry on instance 1.
    WE = 1; inAddr = 3'd0; inData = 16'hffff; WE1 = 1; inAddr1 = 3'd1; inData1 = 16'h1234;
    step();
    WE = 0; WE1 = 0; addrA = 3'd0; addrB = 3'd1; #1;
    check("zero_r0", 32'(outA_w[1]), 32'h0);
    check("zero_r1", 32'(outB_w[1]), 32'h1234);
    check("nozero_r0", 32'(outA_w[0]), 32'hffff);
    check_all("zero");

    // Full sweep with writes attempted while busy.
    fill_all();
    clr_req = 1; step(); clr_req = 0;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      WE = 1; inAddr = 3'($urandom_range(0, 7)); inData = 16'($urandom);
      addrA = 3'(k % 8); addrB = 3'($urandom_range(0, 7));
      #1;
      check_all("sweep");
      if (!busy_w[0]) break;
      busy_cycles++;
      step();
    end
    WE = 0;
    check("sweep_len", 32'(busy_cycles), 32'd8);
    scan_zero("post_sweep");

    // Reset in sweep cycle 3 aborts immediately.
    fill_all();
    clr_req = 1; step(); clr_req = 0;
    step(); step();
    check("mid_busy_pre", 32'(busy_w[0]), 32'h1);
    rst_n = 0; #1;
    check("mid_busy_rst", 32'(busy_w[0]), 32'h0);
    scan_zero("mid_rst");
    step();
    rst_n = 1; #1;
    WE = 1; inAddr = 3'd2; inData = 16'h5a5a; step();
    WE = 0; addrA = 3'd2; #1;
    check("post_rst_wr", 32'(outA_w[1]), 32'h5a5a);
    check_all("post_rst");

    // Randomised traffic including collisions and clear requests.
    for (int n = 0; n < 400; n++) begin
      WE      = 1'($urandom);
      WE1     = 1'($urandom);
      inAddr  = 3'($urandom);
      inAddr1 = ($urandom_range(0, 3) == 0) ? inAddr : 3'($urandom);
      inData  = 16'($urandom);
      inData1 = 16'($urandom);
      clr_req = ($urandom_range(0, 23) == 0);
      addrA   = ($urandom_range(0, 2) == 0) ? inAddr1 : 3'($urandom);
      addrB   = ($urandom_range(0, 2) == 0) ? inAddr  : 3'($urandom);
      #1;
      check_all("rand");
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
